// File: rtl/decoder_rr_arbiter_if.sv
// Requester/arbiter bundle for the round-robin decoder arbiter.
// The requester side drives req/done; the arbiter drives the registered grant outputs.
interface decoder_rr_arbiter_if #(
    parameter int unsigned IDX_W = 4
);
    localparam int unsigned NUM_REQ = 1 << IDX_W;

    logic [NUM_REQ-1:0] req;
    logic               done;
    logic               grant_valid;
    logic [IDX_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] grant_onehot;
    logic               timeout;

    modport master (
        output req,
        output done,
        input  grant_valid,
        input  grant_idx,
        input  grant_onehot,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output grant_valid,
        output grant_idx,
        output grant_onehot,
        output timeout
    );
endinterface

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter sharing one one-hot select resource among 2**IDX_W requesters.
// Grants are held until done, request withdrawal, or the hold limit; all outputs registered.
module decoder_rr_arbiter #(
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    decoder_rr_arbiter_if.slave   bus
);
    localparam int unsigned NUM_REQ   = 1 << IDX_W;
    localparam int unsigned CNT_W     = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int unsigned HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic               grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic [NUM_REQ-1:0] grant_onehot_q, grant_onehot_d;
    logic               timeout_q, timeout_d;

    logic               found_c;
    logic [IDX_W-1:0]   sel_c;
    logic [IDX_W-1:0]   cand_c;
    logic               owner_req_c;
    logic               limit_c;
    logic               release_c;

    // Rotating priority search starting at ptr; index arithmetic wraps naturally.
    always_comb begin
        found_c = 1'b0;
        sel_c   = '0;
        cand_c  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand_c = ptr_q + IDX_W'(i);
            if (!found_c && bus.req[cand_c]) begin
                found_c = 1'b1;
                sel_c   = cand_c;
            end
        end
    end

    always_comb begin
        owner_req_c = bus.req[grant_idx_q];
        limit_c     = (MAX_HOLD != 0) && (hold_cnt_q == CNT_W'(HOLD_LAST));
        release_c   = bus.done || !owner_req_c || limit_c;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        hold_cnt_d     = hold_cnt_q;
        grant_valid_d  = grant_valid_q;
        grant_idx_d    = grant_idx_q;
        grant_onehot_d = grant_onehot_q;
        timeout_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (found_c) begin
                    grant_valid_d  = 1'b1;
                    grant_idx_d    = sel_c;
                    grant_onehot_d = NUM_REQ'(1) << sel_c;
                    hold_cnt_d     = '0;
                    state_d        = BUSY;
                end
            end
            BUSY: begin
                if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
                if (release_c) begin
                    grant_valid_d  = 1'b0;
                    grant_onehot_d = '0;
                    ptr_d          = grant_idx_q + IDX_W'(1);
                    state_d        = IDLE;
                    // Timeout only when the hold limit is the sole release cause.
                    timeout_d      = limit_c && !bus.done && owner_req_c;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            hold_cnt_q     <= '0;
            grant_valid_q  <= 1'b0;
            grant_idx_q    <= '0;
            grant_onehot_q <= '0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            hold_cnt_q     <= hold_cnt_d;
            grant_valid_q  <= grant_valid_d;
            grant_idx_q    <= grant_idx_d;
            grant_onehot_q <= grant_onehot_d;
            timeout_q      <= timeout_d;
        end
    end

    assign bus.grant_valid  = grant_valid_q;
    assign bus.grant_idx    = grant_idx_q;
    assign bus.grant_onehot = grant_onehot_q;
    assign bus.timeout      = timeout_q;
endmodule
